// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_pkg;

  localparam int DATA_W     = 8;  // FIFO data width
  localparam int FIFO_DEPTH = 4;  // entries in the companion FIFO
  localparam int WAIT_W     = 2;  // wait counter width, covers RD_LATENCY up to 4

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } drain_state_t;

endpackage

// File: rtl/fifo_drain.sv
// Read-side controller: pops one byte at a time from the FIFO, waits out the
// read latency, presents the byte on valid/ready and keeps a count and sum of
// every byte delivered downstream.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W     = fifo_pkg::DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              not_empty,
  input  logic [DATA_W-1:0] data,
  output logic              rd_fifo,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_count,
  output logic [CNT_W-1:0]  byte_sum,
  output logic              busy
);

  drain_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  sum_q, sum_d;

  // Next-state and datapath decode; clear overrides the handshake increment.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    case (state_q)
      IDLE: begin
        if (enable && not_empty) state_d = READ;
      end
      READ: begin
        // The pop is committed here; count edges until the data is valid.
        wcnt_d  = WAIT_W'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end else begin
          out_data_d  = data;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          sum_d       = sum_q + CNT_W'(out_data_q);
          state_d     = (enable && not_empty) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      cnt_d = '0;
      sum_d = '0;
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
    end
  end

  // Outputs come straight from state/registers, never from inputs.
  assign rd_fifo    = (state_q == READ);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign byte_count = cnt_q;
  assign byte_sum   = sum_q;

endmodule
